// File: rtl/phy_clk_pol_ctrl.sv
// Clock polarity switch controller: gates the PHY clock, flips the true/inverted
// mux select in the middle of a quiet window, then re-enables the clock and acks.
module phy_clk_pol_ctrl #(
  parameter int unsigned SETTLE_CYC = 4,
  parameter bit          INIT_POL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pol_req,
  input  logic pol_req_val,
  output logic pol_ack,
  output logic busy,
  output logic clk_en,
  output logic inv_sel
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GATE_OFF = 2'd1,
    WAIT_ON  = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pol_req_q;
  logic       target_q, target_d;
  logic       pol_ack_q, pol_ack_d;
  logic       busy_q, busy_d;
  logic       clk_en_q, clk_en_d;
  logic       inv_sel_q, inv_sel_d;
  logic       pol_edge;

  assign pol_edge = pol_req & ~pol_req_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    target_d  = target_q;
    pol_ack_d = 1'b0;
    inv_sel_d = inv_sel_q;

    case (state_q)
      IDLE: begin
        if (pol_edge) begin
          if (pol_req_val == inv_sel_q) begin
            pol_ack_d = 1'b1;
          end else begin
            target_d = pol_req_val;
            cnt_d    = SETTLE_LD;
            state_d  = GATE_OFF;
          end
        end
      end
      GATE_OFF: begin
        // The mux only moves once the gate has been closed for the full settle window.
        if (cnt_q <= 4'd1) begin
          inv_sel_d = target_q;
          cnt_d     = SETTLE_LD;
          state_d   = WAIT_ON;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WAIT_ON: begin
        if (cnt_q <= 4'd1) begin
          cnt_d     = 4'd0;
          pol_ack_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    busy_d   = (state_d != IDLE);
    clk_en_d = !((state_d == GATE_OFF) || (state_d == WAIT_ON));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      pol_req_q <= 1'b0;
      target_q  <= INIT_POL;
      pol_ack_q <= 1'b0;
      busy_q    <= 1'b0;
      clk_en_q  <= 1'b1;
      inv_sel_q <= INIT_POL;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pol_req_q <= pol_req;
      target_q  <= target_d;
      pol_ack_q <= pol_ack_d;
      busy_q    <= busy_d;
      clk_en_q  <= clk_en_d;
      inv_sel_q <= inv_sel_d;
    end
  end

  assign pol_ack = pol_ack_q;
  assign busy    = busy_q;
  assign clk_en  = clk_en_q;
  assign inv_sel = inv_sel_q;

endmodule

// File: tb/tb_phy_clk_pol_ctrl.sv
// Bench for phy_clk_pol_ctrl: two instances (SETTLE_CYC=4/INIT_POL=0 and
// SETTLE_CYC=1/INIT_POL=1) checked each cycle against a timeline model.
module tb_phy_clk_pol_ctrl;

  localparam int S0 = 4;
  localparam int S1 = 1;

  logic       clk;
  logic [1:0] rst, req, val;
  logic [1:0] ack, busy, clk_en, inv;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ack_cnt[2];

  phy_clk_pol_ctrl #(.SETTLE_CYC(S0), .INIT_POL(1'b0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .pol_req(req[0]), .pol_req_val(val[0]),
    .pol_ack(ack[0]), .busy(busy[0]), .clk_en(clk_en[0]), .inv_sel(inv[0])
  );

  phy_clk_pol_ctrl #(.SETTLE_CYC(S1), .INIT_POL(1'b1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .pol_req(req[1]), .pol_req_val(val[1]),
    .pol_ack(ack[1]), .busy(busy[1]), .clk_en(clk_en[1]), .inv_sel(inv[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input int d, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d actual=%b expected=%b", name, d, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d actual=%0d expected=%0d", name, d, cyc, act, exp);
    end
  endtask

  // Model: a switch whose edge lands in cycle N gates the clock in N+1..N+2S,
  // shows the new polarity from N+S+1, and acks/ends busy at N+2S+1.
  initial begin
    bit m_active[2], m_base[2], m_target[2], m_prev[2];
    int m_start[2], m_nack[2];
    int s;
    bit e_busy, e_clk_en, e_inv, e_ack, edge_seen;
    m_base[0] = 1'b0; m_base[1] = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_active[d] = 1'b0; m_target[d] = m_base[d]; m_prev[d] = 1'b0;
      m_start[d] = 0; m_nack[d] = -1; ack_cnt[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        s = (d == 0) ? S0 : S1;
        if (ack[d] === 1'b1) ack_cnt[d]++;
        if (rst[d]) begin
          m_active[d] = 1'b0;
          m_base[d]   = (d == 0) ? 1'b0 : 1'b1;
          m_prev[d]   = 1'b0;
          m_nack[d]   = -1;
          check("rst_busy", d, busy[d], 1'b0);
          check("rst_ack", d, ack[d], 1'b0);
          check("rst_clk_en", d, clk_en[d], 1'b1);
          check("rst_inv", d, inv[d], m_base[d]);
        end else begin
          if (m_active[d] && cyc > m_start[d] + 2*s + 1) begin
            m_base[d]   = m_target[d];
            m_active[d] = 1'b0;
          end
          e_busy   = m_active[d] && cyc >= m_start[d] + 1 && cyc <= m_start[d] + 2*s + 1;
          e_clk_en = !(m_active[d] && cyc >= m_start[d] + 1 && cyc <= m_start[d] + 2*s);
          e_inv    = (m_active[d] && cyc >= m_start[d] + s + 1) ? m_target[d] : m_base[d];
          e_ack    = (m_active[d] && cyc == m_start[d] + 2*s + 1) || (cyc == m_nack[d]);
          check("busy", d, busy[d], e_busy);
          check("clk_en", d, clk_en[d], e_clk_en);
          check("inv_sel", d, inv[d], e_inv);
          check("pol_ack", d, ack[d], e_ack);
          edge_seen = req[d] && !m_prev[d];
          if (edge_seen && !e_busy) begin
            if (val[d] != e_inv) begin
              m_active[d] = 1'b1;
              m_start[d]  = cyc;
              m_target[d] = val[d];
            end else begin
              m_nack[d] = cyc + 1;
            end
          end
          m_prev[d] = req[d];
        end
      end
    end
  end

  // Start of cycle c (just after its rising edge).
  task automatic go(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sampling point (falling edge) of cycle c.
  task automatic at(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic raise(input int d, input logic v, output int n);
    req[d] = 1'b1;
    val[d] = v;
    n = cyc;
    $display("req dut%0d val=%0b edge_cyc=%0d", d, v, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n, m, k, c0;
    rst = 2'b11; req = 2'b00; val = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("por_clk_en", 0, clk_en[0], 1'b1);
    check("por_inv", 0, inv[0], 1'b0);
    check("por_inv", 1, inv[1], 1'b1);

    // Basic switch, edge in the first cycle after reset release.
    @(posedge clk); #1;
    rst = 2'b00;
    raise(0, 1'b1, n);
    at(n+1); check("sw_clk_en_n1", 0, clk_en[0], 1'b0); check("sw_busy_n1", 0, busy[0], 1'b1);
    go(n+2); req[0] = 1'b0; val[0] = 1'b0;
    at(n+4); check("sw_inv_n4", 0, inv[0], 1'b0);
    at(n+5); check("sw_inv_n5", 0, inv[0], 1'b1);
    at(n+8); check("sw_clk_en_n8", 0, clk_en[0], 1'b0);
    at(n+9); check("sw_ack_n9", 0, ack[0], 1'b1); check("sw_clk_en_n9", 0, clk_en[0], 1'b1);
    check("sw_busy_n9", 0, busy[0], 1'b1);
    at(n+10); check("sw_busy_n10", 0, busy[0], 1'b0); check("sw_ack_n10", 0, ack[0], 1'b0);

    // No-change request with inv_sel already 1.
    go(n+12); raise(0, 1'b1, n);
    at(n+1); check("nc_ack", 0, ack[0], 1'b1); check("nc_busy", 0, busy[0], 1'b0);
    check("nc_clk_en", 0, clk_en[0], 1'b1);
    go(n+2); req[0] = 1'b0;
    at(n+2); check("nc_ack_off", 0, ack[0], 1'b0);

    // Second edge while busy is dropped; edge right after IDLE re-entry is taken.
    go(n+5); raise(0, 1'b0, n); c0 = ack_cnt[0];
    go(n+1); req[0] = 1'b0;
    go(n+3); req[0] = 1'b1; val[0] = 1'b1;
    $display("req dut0 val=1 edge_cyc=%0d (while busy)", cyc);
    go(n+4); req[0] = 1'b0;
    at(n+9); check("bz_ack_n9", 0, ack[0], 1'b1); check("bz_inv_n9", 0, inv[0], 1'b0);
    go(n+10); raise(0, 1'b1, m);
    at(m); check("bz_busy_idle", 0, busy[0], 1'b0);
    #1; check_int("bz_ack_count", 0, ack_cnt[0] - c0, 1);
    at(m+1); check("re_busy", 0, busy[0], 1'b1); check("re_clk_en", 0, clk_en[0], 1'b0);
    go(m+2); req[0] = 1'b0;
    at(m+5); check("re_inv", 0, inv[0], 1'b1);
    at(m+9); check("re_ack", 0, ack[0], 1'b1);

    // Reset in cycle 6 of a switch.
    go(m+11); raise(0, 1'b0, n);
    go(n+1); req[0] = 1'b0;
    go(n+6); rst[0] = 1'b1;
    $display("rst dut0 asserted cyc=%0d", cyc);
    #1;
    check("mr_clk_en", 0, clk_en[0], 1'b1); check("mr_inv", 0, inv[0], 1'b0);
    check("mr_busy", 0, busy[0], 1'b0);
    c0 = ack_cnt[0];
    go(n+8); rst[0] = 1'b0;
    at(n+14); #1;
    check_int("mr_no_ack", 0, ack_cnt[0] - c0, 0);

    // SETTLE_CYC=1 instance: no-change, then held request.
    go(n+15); raise(1, 1'b1, m);
    at(m+1); check("b_nc_ack", 1, ack[1], 1'b1); check("b_nc_busy", 1, busy[1], 1'b0);
    go(m+2); req[1] = 1'b0;
    go(m+4); raise(1, 1'b0, m); c0 = ack_cnt[1];
    at(m+1); check("b_busy1", 1, busy[1], 1'b1); check("b_clk_en1", 1, clk_en[1], 1'b0);
    check("b_inv1", 1, inv[1], 1'b1);
    at(m+2); check("b_inv2", 1, inv[1], 1'b0); check("b_clk_en2", 1, clk_en[1], 1'b0);
    at(m+3); check("b_ack3", 1, ack[1], 1'b1); check("b_clk_en3", 1, clk_en[1], 1'b1);
    check("b_busy3", 1, busy[1], 1'b1);
    at(m+4); check("b_busy4", 1, busy[1], 1'b0);
    at(m+8); #1; check_int("b_held_acks", 1, ack_cnt[1] - c0, 1);
    go(m+9); req[1] = 1'b0;
    go(m+10); raise(1, 1'b1, k);
    at(k+1); check("b_again_busy", 1, busy[1], 1'b1);
    at(k+2); check("b_again_inv", 1, inv[1], 1'b1);
    at(k+3); check("b_again_ack", 1, ack[1], 1'b1);
    go(k+4); req[1] = 1'b0;
    at(k+6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phy_clk_pol_ctrl.md
PHY_CLK_POL_CTRL -- requirements
Module: phy_clk_pol_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 4, giving the clock-gated settle cycles before and after the polarity switch; legal range 1..15.
REQ-002 The block SHALL have parameter INIT_POL, default 0, giving the inv_sel value at reset (0 = true clock, 1 = inverted clock).
REQ-003 The block SHALL have port clk, input, 1 bit: the single block clock; all state is clocked on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port pol_req, input, 1 bit: polarity-change request; its rising edge starts a request.
REQ-006 The block SHALL have port pol_req_val, input, 1 bit: requested polarity, sampled on the cycle the pol_req rising edge is detected.
REQ-007 The block SHALL have port pol_ack, output, 1 bit: one-cycle completion pulse.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a switch sequence is in progress.
REQ-009 The block SHALL have port clk_en, output, 1 bit: enable to the clock gate ahead of the true/inverted clock mux.
REQ-010 The block SHALL have port inv_sel, output, 1 bit: select to the mux choosing the inverted clock path.

Function
REQ-011 All outputs SHALL be driven directly from flops, with no combinational path from an input to an output.
REQ-012 Rising-edge detection SHALL use a registered copy pol_req_q; an edge is detected when pol_req=1 and pol_req_q=0.
REQ-013 The state machine SHALL have exactly these states: IDLE, GATE_OFF, WAIT_ON, DONE.
REQ-014 In IDLE, when an edge is detected and pol_req_val equals inv_sel (no change), the block SHALL pulse pol_ack on the next cycle, stay in IDLE, keep busy=0, and leave clk_en unchanged.
REQ-015 In IDLE, when an edge is detected and pol_req_val differs from inv_sel, the block SHALL capture the target value and go to GATE_OFF; busy=1 and clk_en=0 from the next cycle.
REQ-016 In GATE_OFF, a 4-bit down-counter loaded with SETTLE_CYC SHALL keep the state for exactly SETTLE_CYC cycles.
REQ-017 On exit from GATE_OFF, inv_sel SHALL take the captured target value and the state SHALL go to WAIT_ON with the counter reloaded.
REQ-018 In WAIT_ON, the block SHALL keep clk_en=0 for exactly SETTLE_CYC cycles and then go to DONE.
REQ-019 In DONE, lasting one cycle, clk_en SHALL be 1, pol_ack SHALL be 1 and busy SHALL be 1; the next state SHALL be IDLE with busy=0.
REQ-020 For a changing request whose edge is detected in cycle N, the sequence timing SHALL be:
- busy high in cycles N+1 .. N+2*SETTLE_CYC+1
- clk_en low in cycles N+1 .. N+2*SETTLE_CYC
- inv_sel new from cycle N+SETTLE_CYC+1
- pol_ack in cycle N+2*SETTLE_CYC+1
REQ-021 inv_sel SHALL change only while clk_en has been 0 for at least SETTLE_CYC cycles, and clk_en SHALL never be 0 outside GATE_OFF and WAIT_ON.
REQ-022 Edges detected while busy=1 (including in DONE) SHALL be dropped with no ack, and pol_req_q SHALL still track pol_req.
REQ-023 Changes on pol_req_val after the edge cycle SHALL have no effect on the request in progress.
REQ-024 An edge in the first cycle after IDLE is re-entered SHALL be accepted normally.
REQ-025 If pol_req is held high, no new request SHALL be generated; the requester must drop pol_req and raise it again.

Reset
REQ-026 While rst=1, independent of clk, the block SHALL force:
- state = IDLE, counter = 0
- pol_req_q = 0 (a pol_req already high at release counts as an edge)
- pol_ack = 0, busy = 0
- clk_en = 1, inv_sel = INIT_POL
REQ-027 Reset asserted mid-sequence SHALL abort the sequence and leave no pending ack.
REQ-028 After reset release, the first edge SHALL be accepted in the first clocked cycle.

Verification
REQ-029 Bench SHALL cover basic switch: SETTLE_CYC=4, INIT_POL=0, pol_req 0->1 with pol_req_val=1, edge in cycle 0 -> clk_en=0 in cycles 1-8, inv_sel=1 from cycle 5, pol_ack=1 and clk_en=1 in cycle 9, busy=0 in cycle 10.
REQ-030 Bench SHALL cover no-change request: inv_sel=1, request with pol_req_val=1 -> pol_ack in cycle 1, busy stays 0, clk_en stays 1.
REQ-031 Bench SHALL cover request while busy: second pol_req edge in cycle 3 of a switch -> ignored; exactly one pol_ack (cycle 9) and inv_sel toggles once.
REQ-032 Bench SHALL cover mid-sequence reset: rst pulse in cycle 6 of a switch -> clk_en=1, inv_sel=INIT_POL, busy=0 immediately with no clock, no pol_ack afterwards.
REQ-033 Bench SHALL cover SETTLE_CYC=1: change request -> busy for 3 cycles, inv_sel changes in cycle 2, pol_ack in cycle 3.
REQ-034 Bench SHALL cover held request: pol_req held high through and after completion -> a single pol_ack; after pol_req drops and rises again, a new sequence starts.
